// File: rtl/prog_clk_div_pkg.sv
// prog_clk_div_pkg: shared types and helpers
// for the programmable clock divider.
package prog_clk_div_pkg;

  typedef enum logic {
    MODE_50    = 1'b0,
    MODE_PULSE = 1'b1
  } mode_e;

  localparam int unsigned MIN_DIV = 1;

  function automatic int unsigned half_up(
    input int unsigned n
  );
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_phase_gen.sv
// clk_div_phase_gen: period counter, posedge and
// negedge phase flops, clk_out and tick shaping.
module clk_div_phase_gen
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             run_d,
  input  logic             restart,
  input  logic [CNT_W-1:0] div_n,
  input  mode_e            mode,
  output logic             at_end,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half;
  logic             p_ph;
  logic             n_ph;
  logic             bypass;
  logic             odd_50;

  assign cnt_inc = cnt + CNT_W'(1);
  assign half    = CNT_W'(half_up(32'(div_n)));
  assign at_end  = (cnt == div_n - CNT_W'(1));
  assign bypass  = (div_n == CNT_W'(MIN_DIV));
  assign odd_50  = (mode == MODE_50)
                 & div_n[0]
                 & ~bypass;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      p_ph <= 1'b0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      p_ph <= 1'b1;
      tick <= 1'b1;
    end else if (run_d) begin
      cnt  <= cnt_inc;
      p_ph <= (mode == MODE_50)
            & (cnt_inc < half);
      tick <= 1'b0;
    end else begin
      cnt  <= '0;
      p_ph <= 1'b0;
      tick <= 1'b0;
    end
  end

  // Masked in bypass so a switch from N=1 to
  // an odd divisor does not rise half a cycle early.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      n_ph <= 1'b0;
    end else begin
      n_ph <= p_ph & ~bypass;
    end
  end

  always_comb begin
    clk_out = p_ph;
    unique case (1'b1)
      bypass:  clk_out = clk_in & run;
      odd_50:  clk_out = p_ph & n_ph;
      default: clk_out = p_ph;
    endcase
  end

endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: runtime-programmable integer
// clock divider with boundary-aligned reloads.
module prog_clk_divider
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned DEF_DIV = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             mode_pulse,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             load_pending,
  output logic             load_err
);

  logic             run_q;
  logic             run_d;
  logic             bnd;
  logic             restart;
  logic             at_end;
  logic             load_ok;
  logic             load_bad;
  logic [CNT_W-1:0] sh_div;
  logic [CNT_W-1:0] act_div;
  mode_e            sh_mode;
  mode_e            act_mode;
  mode_e            req_mode;

  assign req_mode = mode_pulse ? MODE_PULSE
                               : MODE_50;
  assign load_ok  = div_load
                  & (div_val >= CNT_W'(MIN_DIV));
  assign load_bad = div_load & ~load_ok;

  // Idle counts as a boundary so loads and
  // starts take effect on the very next edge.
  assign bnd     = ~run_q | at_end;
  assign run_d   = bnd ? en : run_q;
  assign restart = bnd & en;

  assign div_active = act_div;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sh_div  <= CNT_W'(DEF_DIV);
      sh_mode <= MODE_50;
    end else if (load_ok) begin
      sh_div  <= div_val;
      sh_mode <= req_mode;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      act_div  <= CNT_W'(DEF_DIV);
      act_mode <= MODE_50;
    end else if (bnd) begin
      if (load_ok) begin
        act_div  <= div_val;
        act_mode <= req_mode;
      end else if (load_pending) begin
        act_div  <= sh_div;
        act_mode <= sh_mode;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      load_pending <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      load_err <= load_bad;
      if (bnd) begin
        load_pending <= 1'b0;
      end else if (load_ok) begin
        load_pending <= 1'b1;
      end
    end
  end

  clk_div_phase_gen #(
    .CNT_W (CNT_W)
  ) u_phase (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .run     (run_q),
    .run_d   (run_d),
    .restart (restart),
    .div_n   (act_div),
    .mode    (act_mode),
    .at_end  (at_end),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: scoreboard bench with a
// period-level reference model of the divider.
module tb_prog_clk_divider;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DEF_DIV = 3;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             en     = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             mode_pulse = 1'b0;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] div_active;
  logic             load_pending;
  logic             load_err;

  prog_clk_divider #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .en           (en),
    .div_val      (div_val),
    .div_load     (div_load),
    .mode_pulse   (mode_pulse),
    .clk_out      (clk_out),
    .tick         (tick),
    .div_active   (div_active),
    .load_pending (load_pending),
    .load_err     (load_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          tick;
    int unsigned div;
    bit          pend;
    bit          err;
    bit          c0;
    bit          c1;
  } exp_t;

  exp_t sbq[$];

  int n_vec = 0;
  int n_bad = 0;

  // model state: position inside the current period
  bit          m_run;
  int unsigned m_pos;
  int unsigned m_n;
  bit          m_pm;
  int unsigned m_sh_n;
  bit          m_sh_pm;
  bit          m_pend;
  bit          m_err;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d",
               name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_run   = 0;
    m_pos   = 0;
    m_n     = DEF_DIV;
    m_pm    = 0;
    m_sh_n  = DEF_DIV;
    m_sh_pm = 0;
    m_pend  = 0;
    m_err   = 0;
  endtask

  // clk_out level in half-cycle hf (0: after posedge)
  function automatic bit exp_clk(input int unsigned hf);
    int unsigned h;
    h = 2 * m_pos + hf;
    if (!m_run)      return 1'b0;
    if (m_n == 1)    return hf == 0;
    if (m_pm)        return m_pos == 0;
    if (m_n % 2 == 0) return h < m_n;
    return (h >= 1) && (h <= m_n);
  endfunction

  task automatic model();
    bit          ok;
    bit          bnd;
    int unsigned v;
    exp_t        e;
    if (!rst_n) begin
      m_reset();
    end else begin
      v     = int'(div_val);
      ok    = div_load && (v != 0);
      m_err = div_load && (v == 0);
      bnd   = !m_run || (m_pos == m_n - 1);
      if (ok) begin
        m_sh_n  = v;
        m_sh_pm = mode_pulse;
      end
      if (bnd) begin
        if (ok || m_pend) begin
          m_n  = m_sh_n;
          m_pm = m_sh_pm;
        end
        m_pend = 0;
        m_run  = en;
        m_pos  = 0;
      end else begin
        m_pos++;
        if (ok) m_pend = 1;
      end
    end
    e.tick = m_run && (m_pos == 0);
    e.div  = m_n;
    e.pend = m_pend;
    e.err  = m_err;
    e.c0   = exp_clk(0);
    e.c1   = exp_clk(1);
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_in);
    model();
    #2;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic load(input int unsigned v,
                      input bit pm);
    div_val    = CNT_W'(v);
    mode_pulse = pm;
    div_load   = 1'b1;
    step();
    div_load   = 1'b0;
  endtask

  task automatic wait_at(input int unsigned n,
                         input int unsigned pos,
                         input string what);
    int k;
    k = 0;
    while (!(m_run && m_n == n && m_pos == pos)) begin
      if (k == 200) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: timeout waiting n=%0d pos=%0d",
                 what, n, pos);
        return;
      end
      step();
      k++;
    end
  endtask

  initial begin : monitor
    exp_t cur;
    forever begin
      @(posedge clk_in);
      #1;
      if (sbq.size() != 0) begin
        cur = sbq.pop_front();
        chk("tick", 32'(tick), 32'(cur.tick));
        chk("div_active", 32'(div_active), cur.div);
        chk("load_pending", 32'(load_pending),
            32'(cur.pend));
        chk("load_err", 32'(load_err), 32'(cur.err));
        chk("clk_out_h0", 32'(clk_out), 32'(cur.c0));
        @(negedge clk_in);
        #1;
        chk("clk_out_h1", 32'(clk_out), 32'(cur.c1));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    m_reset();
    run(3);
    rst_n = 1'b1;
    run(2);
    en = 1'b1;
    run(12);

    wait_at(3, 0, "load4");
    load(4, 0);
    run(14);

    wait_at(4, 1, "load5");
    load(5, 1);
    load(7, 1);
    run(22);

    load(0, 0);
    run(9);

    load(6, 0);
    wait_at(6, 1, "stop6");
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(14);

    load(1, 0);
    run(5);
    // mid high phase of clk_in, bypass running
    rst_n = 1'b0;
    #1;
    chk("async_clk_out", 32'(clk_out), 32'd0);
    chk("async_div", 32'(div_active), DEF_DIV);
    chk("async_tick", 32'(tick), 32'd0);
    m_reset();
    run(2);
    rst_n = 1'b1;
    run(8);

    for (int i = 0; i < 2500; i++) begin
      int unsigned r;
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 15);
        div_val = (r == 15) ? CNT_W'($urandom_range(16, 40))
                            : CNT_W'(r);
        mode_pulse = 1'($urandom_range(0, 1));
        div_load   = 1'b1;
      end
      step();
      div_load = 1'b0;
    end

    step();
    #10;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Runtime-programmable integer clock divider; successor to the fixed-N divider.
- Divisor and duty mode can be changed on the fly; changes are applied only at period boundaries, so clk_out never shows a truncated or glitched period.
- Odd divisors produce exact 50% duty in 50% mode, using a negedge-sampled copy of the posedge phase.
- Provides a posedge-domain tick strobe for logic that must not use clk_out as a clock.

Parameters:
- CNT_W, 10: divisor and counter width; legal divisors are 1..2^CNT_W-1.
- DEF_DIV, 3: divisor active after reset; must be 1..2^CNT_W-1.

Ports:
- clk_in  in  1  source clock
- rst_n  in  1  reset
- en  in  1  run enable, sampled on posedge clk_in
- div_val  in  CNT_W  requested divisor
- div_load  in  1  one-cycle strobe that captures div_val and mode_pulse
- mode_pulse  in  1  0 = 50% duty; 1 = clk_out high for one clk_in cycle per period
- clk_out  out  1  divided clock
- tick  out  1  one-clk_in-cycle pulse in the posedge domain, high in the cycle clk_out rises
- div_active  out  CNT_W  divisor currently in use
- load_pending  out  1  a captured divisor/mode is waiting for the next boundary
- load_err  out  1  one-cycle pulse when div_load is sampled with div_val == 0

Interface (already decided):
- One clock, clk_in.
- Reset rst_n is asynchronous and active-low.
- The negedge flop is clocked by the falling edge of clk_in; there is no second clock.

Behaviour:
- Reset values:
  - cnt = 0; p_ph = 0; n_ph = 0; clk_out = 0; tick = 0.
  - div_active = DEF_DIV; active mode = 50%.
  - shadow regs = DEF_DIV / 50%; load_pending = 0; load_err = 0.
- Counter: cnt runs 0..N-1 on posedge, where N = div_active. A boundary is a posedge at which cnt == N-1 (or a start from idle).
- Phase, 50% mode:
  - p_ph is high for cnt in 0..H-1, where H = (N+1)/2 (integer division).
  - n_ph = p_ph resampled on negedge clk_in.
  - N even: clk_out = p_ph. N odd: clk_out = p_ph & n_ph.
  - Result: high time exactly N/2 input periods, e.g. N=5 gives 2.5 high / 2.5 low.
- Phase, pulse mode: clk_out = p_ph, with p_ph high only for cnt == 0.
- N == 1:
  - clk_out = clk_in AND a posedge-registered run flag; this is the only combinational clock path and uses a gated-AND structure.
  - tick is high every cycle while running.
- tick = 1 in every posedge cycle where cnt == 0 while running.
- Start:
  - When idle and en is sampled 1 at posedge k, cnt = 0 and p_ph = 1 from edge k.
  - clk_out rises at edge k (half a cycle later for the odd-N falling path); tick is high in cycle k.
- Stop:
  - When en is sampled 0 mid-period, the current period completes.
  - At the boundary the block goes idle: cnt held at 0, clk_out = 0, tick = 0.
  - Idle state is never entered mid-period.
- Load:
  - div_load with div_val ≠ 0 writes the shadow divisor and shadow mode, and sets load_pending.
  - At the next boundary (or immediately when idle), the shadow values are copied to the active values and load_pending clears.
  - A div_load on the same edge as a boundary takes effect at that boundary.
  - Repeated loads before a boundary: the last one wins.
- Load error: div_val == 0 on div_load pulses load_err for one cycle; shadow and pending state are unchanged.
- Reset mid-operation: asynchronous return to the reset values; any pending load is discarded.
- Widths:
  - cnt is CNT_W bits; H is computed CNT_W bits wide.
  - No wrap-around is possible, because cnt < N ≤ 2^CNT_W-1.

Decomposition:
- Package prog_clk_div_pkg:
  - mode enum: MODE_50, MODE_PULSE.
  - function half_up(N) = (N+1)/2.
  - constant MIN_DIV = 1.
- One natural sub-module, clk_div_phase_gen:
  - Contains the posedge counter, p_ph and the negedge n_ph flop.
  - Produces clk_out and tick from the active N and mode.
- The top level holds the shadow and active registers, the load/error logic and the en/idle control.

Test Plan:
- Reset, en=1, no load (DEF_DIV=3) → clk_out period 3 clk_in cycles, high 1.5 cycles, tick every 3rd cycle, div_active=3.
- Load 4 at mid-period → load_pending=1 until the boundary; the current period stays 3 cycles; subsequent periods are 4 cycles with 2 high / 2 low; load_pending=0.
- Load 5 with mode_pulse=1, then load 7 before the boundary → only 7 is applied; clk_out is high for 1 cycle in every 7.
- Load div_val=0 → load_err is one pulse; div_active and load_pending are unchanged; clk_out is undisturbed.
- Drop en at cnt=1 with N=6 → clk_out completes the full 6-cycle period, then stays 0; re-raising en makes clk_out rise at the first sampling edge, with tick high.
- Assert rst_n low mid-high-phase with N=1 bypass → clk_out=0 immediately (asynchronously); after release, div_active=DEF_DIV.
